// File: rtl/alu_shift_pkg.sv
// Shared definitions for the iterative ALU shift unit: op and FSM state encodings
// plus the fixed datapath dimensions.
package alu_shift_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_RSVD = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single step of the iterative shifter: moves the value by 1 or 2
// bit positions using the fill rule of the selected op.
module shift_step_unit
    import alu_shift_pkg::*;
(
    input  logic [WIDTH-1:0] value,
    input  shift_op_e        op,
    input  logic             two_bits,
    output logic [WIDTH-1:0] shifted
);

    // NOTE: assign a default first so every path drives the output; no latch is inferred.
    always_comb begin
        shifted = value;
        case (op)
            SHIFT_SLL: shifted = two_bits ? {value[WIDTH-3:0], 2'b00}
                                          : {value[WIDTH-2:0], 1'b0};
            SHIFT_SRL: shifted = two_bits ? {2'b00, value[WIDTH-1:2]}
                                          : {1'b0, value[WIDTH-1:1]};
            // Arithmetic fill replicates the current sign bit of the work value.
            SHIFT_SRA: shifted = two_bits ? {{2{value[WIDTH-1]}}, value[WIDTH-1:2]}
                                          : {value[WIDTH-1], value[WIDTH-1:1]};
            default:   shifted = value;
        endcase
    end

endmodule

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle shift controller: accepts one request at a time, walks the shift amount
// down in 2-bit (or 1-bit) steps and presents a registered result with a one-cycle pulse.
module iter_shift_ctrl #(
    parameter int WIDTH     = 32,
    parameter int SHAMT_W   = 5,
    parameter int USE_STEP2 = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic [WIDTH-1:0]   result,
    output logic               result_rdy,
    output logic               busy,
    output logic               op_error
);
    import alu_shift_pkg::*;

    shift_state_e       state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    shift_op_e          op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               two_bits;
    logic [SHAMT_W-1:0] step;
    logic [SHAMT_W-1:0] count_dec;
    logic [WIDTH-1:0]   stepped;

    shift_step_unit u_step (
        .value    (work_q),
        .op       (op_q),
        .two_bits (two_bits),
        .shifted  (stepped)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            count_q  <= '0;
            op_q     <= SHIFT_SLL;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            count_q  <= count_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        count_d   = count_q;
        op_d      = op_q;
        result_d  = result_q;
        two_bits  = (USE_STEP2 != 0) && (count_q >= SHAMT_W'(2));
        step      = two_bits ? SHAMT_W'(2) : SHAMT_W'(1);
        count_dec = count_q - step;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d  = A;
                    count_d = shamt;
                    op_d    = shift_op_e'(op);
                    // Reserved op and zero shift finish on the accept edge with A untouched.
                    if (op == SHIFT_RSVD || shamt == '0) begin
                        state_d  = DONE;
                        result_d = A;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d  = stepped;
                count_d = count_dec;
                if (count_dec == '0) begin
                    state_d  = DONE;
                    result_d = stepped;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign result     = result_q;
    assign result_rdy = (state_q == DONE);
    assign busy       = (state_q == SHIFT);
    assign op_error   = (state_q == DONE) && (op_q == SHIFT_RSVD);

endmodule
